mult_sched: RTL and testbench

MULT_SCHED -- requirements
Module: mult_sched

---
 rtl/mult_sched.sv | 199 +++++++++++++++++++
 tb/tb_mult_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sched.sv
// mult_sched: arbitrating controller for a shift-add multiplier datapath.
// Requesters raise a level on req. While idle, the controller picks one of
// them, latches its operands and sequences the external datapath through
// LOAD / TEST / ADD / SHIFT / DECR until the datapath's counter reaches
// zero. It then captures the product and tags it with the owner index.
//
// Build option: define MULT_SCHED_RR_EN for round-robin arbitration.
// Without it, arbitration is fixed priority (lowest index wins) and no
// pointer register exists.
//
// Handshake: req is a level per requester. gnt is a one-hot pulse that is
// high for exactly the LOAD cycle and marks acceptance of that requester's
// operands. Requests are only sampled while idle. A req still high after its
// gnt is treated as a fresh request. Results have no backpressure: res_valid
// pulses for the DONE cycle, and res/res_id hold until the next DONE.
module mult_sched #(
  parameter int BITS = 8,
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BITS-1:0] op_b,
  input  logic [NREQ*BITS-1:0] op_q,
  output logic [NREQ-1:0]      gnt,
  output logic                 Load_Regs,
  output logic                 Shift_Regs,
  output logic                 Add_Regs,
  output logic                 Decr_P,
  output logic [BITS-1:0]      DP_B,
  output logic [BITS-1:0]      DP_Q,
  input  logic                 Q0,
  input  logic                 Zero,
  input  logic [2*BITS:0]      Producto,
  output logic [2*BITS:0]      res,
  output logic                 res_valid,
  output logic [IW-1:0]        res_id,
  output logic                 busy,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DECR  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t          cur;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   win_idx;
  logic            any_req;
  logic [BITS-1:0] b_slice [NREQ];
  logic [BITS-1:0] q_slice [NREQ];

`ifdef MULT_SCHED_RR_EN
  logic [IW-1:0]   rr_ptr;
  logic [IW:0]     rr_sum;
  logic [IW-1:0]   rr_cand;
`endif

  // The current state is visible on the debug port.
  assign state = cur;

  // Split the packed operand buses into per-requester slices.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      b_slice[i] = op_b[i*BITS +: BITS];
      q_slice[i] = op_q[i*BITS +: BITS];
    end
  end

`ifdef MULT_SCHED_RR_EN
  // Round-robin winner: first requester at or after the pointer, wrapping.
  // The loop runs from the farthest offset down so the nearest one wins.
  always_comb begin
    any_req = |req;
    win_idx = '0;
    rr_sum  = '0;
    rr_cand = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      rr_sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (rr_sum >= (IW+1)'(NREQ)) begin
        rr_sum = rr_sum - (IW+1)'(NREQ);
      end
      rr_cand = rr_sum[IW-1:0];
      if (req[rr_cand]) begin
        win_idx = rr_cand;
      end
    end
  end
`else
  // Fixed-priority winner: the lowest requesting index.
  always_comb begin
    any_req = |req;
    win_idx = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req[k]) begin
        win_idx = IW'(k);
      end
    end
  end
`endif

  // Sequencer: state, registered datapath controls, grant and result capture.
  // Every output is registered from the state being entered, so each control
  // lines up exactly with the cycle of the state that owns it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur        <= S_IDLE;
      owner      <= '0;
      gnt        <= '0;
      Load_Regs  <= 1'b0;
      Shift_Regs <= 1'b0;
      Add_Regs   <= 1'b0;
      Decr_P     <= 1'b0;
      DP_B       <= '0;
      DP_Q       <= '0;
      res        <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      busy       <= 1'b0;
`ifdef MULT_SCHED_RR_EN
      rr_ptr     <= '0;
`endif
    end else begin
      // Pulses default low; the case below raises the one that applies.
      gnt        <= '0;
      Load_Regs  <= 1'b0;
      Shift_Regs <= 1'b0;
      Add_Regs   <= 1'b0;
      Decr_P     <= 1'b0;
      res_valid  <= 1'b0;
      case (cur)
        S_IDLE: begin
          if (any_req) begin
            cur       <= S_LOAD;
            busy      <= 1'b1;
            gnt       <= NREQ'(1) << win_idx;
            Load_Regs <= 1'b1;
            owner     <= win_idx;
            DP_B      <= b_slice[win_idx];
            DP_Q      <= q_slice[win_idx];
`ifdef MULT_SCHED_RR_EN
            rr_ptr    <= (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
`endif
          end
        end
        S_LOAD: begin
          cur <= S_TEST;
        end
        S_TEST: begin
          // The zero counter ends the operation even when Q0 is set.
          if (Zero) begin
            cur       <= S_DONE;
            res       <= Producto;
            res_id    <= owner;
            res_valid <= 1'b1;
          end else if (Q0) begin
            cur      <= S_ADD;
            Add_Regs <= 1'b1;
          end else begin
            cur        <= S_SHIFT;
            Shift_Regs <= 1'b1;
          end
        end
        S_ADD: begin
          cur        <= S_SHIFT;
          Shift_Regs <= 1'b1;
        end
        S_SHIFT: begin
          cur    <= S_DECR;
          Decr_P <= 1'b1;
        end
        S_DECR: begin
          cur <= S_TEST;
        end
        S_DONE: begin
          cur  <= S_IDLE;
          busy <= 1'b0;
          DP_B <= '0;
          DP_Q <= '0;
        end
        default: begin
          // The unused code recovers to idle with operands cleared.
          cur  <= S_IDLE;
          busy <= 1'b0;
          DP_B <= '0;
          DP_Q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: a small shift-add datapath answers the controller,
// and a transaction-level model predicts grants, timing and results.
module tb_mult_sched;

  localparam int BITS = 8;
  localparam int NREQ = 4;
  localparam int IW   = $clog2(NREQ);
  localparam int PW   = 2*BITS+1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  logic [NREQ-1:0]      req;
  logic [NREQ*BITS-1:0] op_b_v;
  logic [NREQ*BITS-1:0] op_q_v;
  logic [NREQ-1:0]      gnt;
  logic                 load_regs, shift_regs, add_regs, decr_p;
  logic [BITS-1:0]      dp_b, dp_q;
  logic                 q0, zero;
  logic [PW-1:0]        producto;
  logic [PW-1:0]        res;
  logic                 res_valid;
  logic [IW-1:0]        res_id;
  logic                 busy;
  logic [2:0]           state;

  mult_sched #(.BITS(BITS), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .op_b(op_b_v), .op_q(op_q_v),
    .gnt(gnt), .Load_Regs(load_regs), .Shift_Regs(shift_regs),
    .Add_Regs(add_regs), .Decr_P(decr_p), .DP_B(dp_b), .DP_Q(dp_q),
    .Q0(q0), .Zero(zero), .Producto(producto), .res(res),
    .res_valid(res_valid), .res_id(res_id), .busy(busy), .state(state)
  );

  // ---------------- external datapath ----------------
  logic [BITS-1:0] dp_a, dp_qr, dp_br;
  logic            dp_c;
  logic [7:0]      dp_p;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_a <= '0; dp_qr <= '0; dp_br <= '0; dp_c <= 1'b0; dp_p <= '0;
    end else if (load_regs) begin
      dp_a <= '0; dp_c <= 1'b0; dp_qr <= dp_q; dp_br <= dp_b; dp_p <= 8'(BITS);
    end else if (add_regs) begin
      {dp_c, dp_a} <= {1'b0, dp_a} + {1'b0, dp_br};
    end else if (shift_regs) begin
      {dp_c, dp_a, dp_qr} <= {1'b0, dp_c, dp_a, dp_qr[BITS-1:1]};
    end else if (decr_p) begin
      dp_p <= dp_p - 8'd1;
    end
  end

  assign q0       = dp_qr[0];
  assign zero     = (dp_p == 8'd0);
  assign producto = {dp_c, dp_a, dp_qr};

  // ---------------- scoreboard / counters ----------------
  int n_checks;
  int n_errors;
  logic [IW+PW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic            m_active;
  int              m_start, m_len, m_adds, m_id;
  logic [BITS-1:0] m_b, m_q;
  logic [PW-1:0]   m_res;
  logic [IW-1:0]   m_id_last;
`ifdef MULT_SCHED_RR_EN
  int              m_ptr;
`endif

  // Monitor facts used by the directed tests.
  int gnt_cnt, done_cnt, last_gnt_cyc, last_done_cyc, add_obs;
  int gnt_log[$];

  function automatic int pick(input logic [NREQ-1:0] r);
    int s;
    s = 0;
`ifdef MULT_SCHED_RR_EN
    s = m_ptr;
`endif
    for (int k = 0; k < NREQ; k++)
      if (r[(s+k) % NREQ]) return (s+k) % NREQ;
    return 0;
  endfunction

  initial begin : model_compare
    int k;
    int unsigned pr;
    logic [IW+PW-1:0] e;
    m_active = 1'b0; m_start = 0; m_len = 0; m_adds = 0; m_id = 0;
    m_b = '0; m_q = '0; m_res = '0; m_id_last = '0;
`ifdef MULT_SCHED_RR_EN
    m_ptr = 0;
`endif
    gnt_cnt = 0; done_cnt = 0; last_gnt_cyc = 0; last_done_cyc = 0; add_obs = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_active = 1'b0; m_res = '0; m_id_last = '0;
        exp_q.delete();
`ifdef MULT_SCHED_RR_EN
        m_ptr = 0;
`endif
        check("reset_outputs", {gnt, load_regs, shift_regs, add_regs, decr_p, dp_b, dp_q,
                                res, res_valid, res_id, busy, state}, '0);
      end else begin
        k = 0;
        if (m_active) begin
          k = cyc - m_start + 1;
          check("busy_active", busy, 1);
          check("dp_b_held", dp_b, m_b);
          check("dp_q_held", dp_q, m_q);
          if (add_regs) m_adds++;
          if (k == 1) begin
            check("gnt_onehot", gnt, NREQ'(1) << m_id);
            check("load_state", state, 1);
            check("load_ctrls", {load_regs, shift_regs, add_regs, decr_p}, 4'b1000);
          end else begin
            check("gnt_idle_busy", gnt, 0);
          end
          if (k == m_len) begin
            check("done_state", state, 6);
            check("done_ctrls", {load_regs, shift_regs, add_regs, decr_p}, 0);
            check("res_valid_done", res_valid, 1);
            check("add_pulses", m_adds, $countones(m_q));
            if (exp_q.size() == 0) begin
              check("exp_q_nonempty", 0, 1);
            end else begin
              e = exp_q.pop_front();
              check("res_value", res, e[PW-1:0]);
              check("res_id", res_id, e[IW+PW-1:PW]);
              m_res = e[PW-1:0];
              m_id_last = e[IW+PW-1:PW];
            end
          end else begin
            check("res_valid_low", res_valid, 0);
            check("res_hold_busy", {res_id, res}, {m_id_last, m_res});
            if (k > 1) begin
              check("mid_state_range", (state >= 3'd2 && state <= 3'd5), 1);
              check("mid_ctrls", {load_regs, shift_regs, add_regs, decr_p},
                    {1'b0, state == 3'd4, state == 3'd3, state == 3'd5});
            end
          end
        end else begin
          check("idle_state", state, 0);
          check("idle_busy", busy, 0);
          check("idle_outputs", {gnt, load_regs, shift_regs, add_regs, decr_p, dp_b, dp_q, res_valid}, 0);
          check("res_hold_idle", {res_id, res}, {m_id_last, m_res});
        end

        // Monitor facts for directed tests.
        if (gnt != 0) begin
          gnt_cnt++;
          last_gnt_cyc = cyc;
          add_obs = 0;
          for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);
        end
        if (add_regs) add_obs++;
        if (res_valid) begin
          done_cnt++;
          last_done_cyc = cyc;
        end

        // Predict what the next edge does.
        if (m_active) begin
          if (k == m_len) m_active = 1'b0;
        end else if (req != 0) begin
          m_id     = pick(req);
          m_b      = op_b_v[m_id*BITS +: BITS];
          m_q      = op_q_v[m_id*BITS +: BITS];
          m_start  = cyc + 1;
          m_len    = 3 + 3*BITS + $countones(m_q);
          m_adds   = 0;
          m_active = 1'b1;
          pr       = int'(m_b) * int'(m_q);
          exp_q.push_back({IW'(m_id), PW'(pr)});
`ifdef MULT_SCHED_RR_EN
          m_ptr = (m_id + 1) % NREQ;
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_gnt(input int g0, input int limit, input string name);
    int t;
    t = 0;
    while (gnt_cnt == g0 && t < limit) begin step(1); t++; end
    check(name, gnt_cnt != g0, 1);
  endtask

  task automatic wait_done(input int d0, input int limit, input string name);
    int t;
    t = 0;
    while (done_cnt == d0 && t < limit) begin step(1); t++; end
    check(name, done_cnt != d0, 1);
  endtask

  task automatic run_single(input int id, input logic [BITS-1:0] b, input logic [BITS-1:0] q,
                            input logic [PW-1:0] exp_res, input int exp_len,
                            input int exp_adds, input string tag);
    int g0, d0;
    op_b_v[id*BITS +: BITS] = b;
    op_q_v[id*BITS +: BITS] = q;
    g0 = gnt_cnt;
    d0 = done_cnt;
    req = NREQ'(1) << id;
    wait_gnt(g0, 20, {tag, "_gnt_seen"});
    req = '0;  // dropped in the cycle after gnt; the operation must finish
    wait_done(d0, 100, {tag, "_done_seen"});
    check({tag, "_length"}, last_done_cyc - last_gnt_cyc + 1, exp_len);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_res_id"}, res_id, id);
    check({tag, "_adds"}, add_obs, exp_adds);
    step(3);
  endtask

  // ---------------- stimulus ----------------
  int rr_exp[5];
  int d_before;

  initial begin : stimulus
    rst = 1'b0; req = '0; op_b_v = '0; op_q_v = '0;
    n_checks = 0; n_errors = 0;
    step(3);
    rst = 1'b1;
    step(1);
    check("post_reset_state", state, 0);

    // Directed operations with hand-computed results.
    run_single(0, 8'h0D, 8'h0B, 17'h0008F, 30, 3, "op_0d_0b");
    run_single(1, 8'hFF, 8'h00, 17'h00000, 27, 0, "op_ff_00");
    run_single(3, 8'hFF, 8'hFF, 17'h0FE01, 35, 8, "op_ff_ff");
    run_single(2, 8'h5A, 8'h3C, 17'h01518, 31, 4, "op_drop_req2");

    // Reset in cycle 10 of an operation.
    op_b_v[1*BITS +: BITS] = 8'h77;
    op_q_v[1*BITS +: BITS] = 8'h55;
    d_before = done_cnt;
    req = 4'b0010;
    wait_gnt(gnt_cnt, 20, "rst_op_gnt");
    repeat (8) @(posedge clk);
    #3;
    check("rst_pre_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("rst_async_zero", {gnt, load_regs, shift_regs, add_regs, decr_p, dp_b, dp_q,
                             res, res_valid, res_id, busy, state}, '0);
    step(2);
    rst = 1'b1;
    wait_gnt(gnt_cnt, 5, "rst_regrant");
    check("rst_no_result", done_cnt, d_before);
    req = '0;
    wait_done(d_before, 100, "rst_regrant_done");
    step(3);

    // Continuous requests from everyone, starting from a fresh pointer.
    rst = 1'b0;
    step(2);
    rst = 1'b1;
`ifdef MULT_SCHED_RR_EN
    rr_exp = '{0, 1, 2, 3, 0};
`else
    rr_exp = '{0, 0, 0, 0, 0};
`endif
    op_b_v = $urandom;
    op_q_v = $urandom;
    gnt_log.delete();
    req = 4'b1111;
    begin
      int t;
      t = 0;
      while (gnt_log.size() < 5 && t < 400) begin step(1); t++; end
    end
    req = '0;
    check("arb_grant_count", gnt_log.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      check("arb_order", (i < gnt_log.size()) ? gnt_log[i] : 99, rr_exp[i]);
    step(60);

    // Randomized traffic checked cycle by cycle against the model.
    d_before = done_cnt;
    for (int c = 0; c < 3000; c++) begin
      step(1);
      if ($urandom_range(0, 7) == 0) req = NREQ'($urandom_range(0, 15));
      op_b_v = $urandom;
      op_q_v = $urandom;
    end
    req = '0;
    step(60);
    check("random_ops_done", (done_cnt - d_before) >= 30, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
